// File: rtl/deal_sequencer_pkg.sv
// Shared types and constants for the blackjack deal sequencer: FSM states,
// turn/result codes, card rank type and card-value helpers.
package deal_sequencer_pkg;

    typedef logic [3:0] rank_t;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_DEAL_P1     = 4'd1,
        ST_DEAL_D1     = 4'd2,
        ST_DEAL_P2     = 4'd3,
        ST_DEAL_D2     = 4'd4,
        ST_PLAYER_TURN = 4'd5,
        ST_PLAYER_DRAW = 4'd6,
        ST_DEALER_TURN = 4'd7,
        ST_DEALER_DRAW = 4'd8,
        ST_RESOLVE     = 4'd9,
        ST_DONE        = 4'd10
    } game_state_e;

    typedef enum logic [1:0] {
        TURN_NONE   = 2'd0,
        TURN_PLAYER = 2'd1,
        TURN_DEALER = 2'd2
    } turn_e;

    typedef enum logic [1:0] {
        RES_NONE       = 2'd0,
        RES_PLAYER_WIN = 2'd1,
        RES_DEALER_WIN = 2'd2,
        RES_PUSH       = 2'd3
    } result_e;

    localparam logic [4:0] BUST_LIMIT = 5'd21;
    localparam logic [4:0] ACE_HIGH   = 5'd11;
    localparam logic [4:0] FACE_VALUE = 5'd10;

    function automatic logic [4:0] card_value(input rank_t rank);
        logic [4:0] value;
        if (rank == 4'd1) begin
            value = ACE_HIGH;
        end else if (rank >= 4'd10) begin
            value = FACE_VALUE;
        end else begin
            value = {1'b0, rank};
        end
        return value;
    endfunction

    function automatic logic is_draw_state(input game_state_e state);
        logic draw;
        case (state)
            ST_DEAL_P1, ST_DEAL_D1, ST_DEAL_P2, ST_DEAL_D2,
            ST_PLAYER_DRAW, ST_DEALER_DRAW: draw = 1'b1;
            default:                        draw = 1'b0;
        endcase
        return draw;
    endfunction

    function automatic turn_e turn_of(input game_state_e state);
        turn_e turn;
        case (state)
            ST_PLAYER_TURN, ST_PLAYER_DRAW: turn = TURN_PLAYER;
            ST_DEALER_TURN, ST_DEALER_DRAW: turn = TURN_DEALER;
            default:                        turn = TURN_NONE;
        endcase
        return turn;
    endfunction

endpackage

// File: rtl/deal_sequencer_hand_accumulator.sv
// One blackjack hand: running best total, card count and soft-ace count.
// The post-add values are also exported so the sequencer can branch on them.
module hand_accumulator
    import deal_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       add,
    input  rank_t      rank,
    output logic [4:0] total,
    output logic [2:0] count,
    output logic [2:0] soft_aces,
    output logic [4:0] total_next,
    output logic [2:0] count_next
);

    logic [5:0] sum_s;
    logic [5:0] adj_s;
    logic [2:0] soft_s;
    logic [2:0] soft_next_s;

    // Add the card and demote at most one soft ace back to 1
    always_comb begin
        sum_s       = {1'b0, total} + {1'b0, card_value(rank)};
        soft_s      = soft_aces + ((rank == 4'd1) ? 3'd1 : 3'd0);
        adj_s       = sum_s;
        soft_next_s = soft_s;
        if ((sum_s > {1'b0, BUST_LIMIT}) && (soft_s != 3'd0)) begin
            adj_s       = sum_s - 6'd10;
            soft_next_s = soft_s - 3'd1;
        end else begin
            adj_s       = sum_s;
            soft_next_s = soft_s;
        end
        // Saturate instead of wrapping; unreachable under legal play
        total_next = adj_s[5] ? 5'd31 : adj_s[4:0];
        count_next = (count == 3'd7) ? count : count + 3'd1;
    end

    // Hand registers; reset and clear dominate an accepted card
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            total     <= 5'd0;
            count     <= 3'd0;
            soft_aces <= 3'd0;
        end else if (add) begin
            total     <= total_next;
            count     <= count_next;
            soft_aces <= soft_next_s;
        end
    end

endmodule

// File: rtl/deal_sequencer.sv
// Blackjack round sequencer: deals P1/D1/P2/D2, runs player and dealer turns
// against a request/strobe deck interface, and resolves the round.
module deal_sequencer
    import deal_sequencer_pkg::*;
#(
    parameter int MAX_CARDS    = 5,
    parameter int DEALER_STAND = 17
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_hit,
    input  logic       i_stand,
    input  logic       i_cardValid,
    input  logic [3:0] i_cardRank,
    output logic       o_drawReq,
    output logic [4:0] o_playerTotal,
    output logic [4:0] o_dealerTotal,
    output logic [2:0] o_playerCount,
    output logic [2:0] o_dealerCount,
    output logic [1:0] o_turn,
    output logic [3:0] o_state,
    output logic [1:0] o_result
);

    localparam logic [4:0] STAND_TOTAL = 5'(DEALER_STAND);
    localparam logic [2:0] MAX_COUNT   = 3'(MAX_CARDS);

    game_state_e state_r, state_s;
    result_e     result_r, result_s;
    turn_e       turn_r;
    logic        drawreq_r;
    logic        clear_s, add_player_s, add_dealer_s;
    logic [4:0]  player_total_s, dealer_total_s, player_total_next_s, dealer_total_next_s;
    logic [2:0]  player_count_s, dealer_count_s, player_count_next_s, dealer_count_next_s;
    logic [2:0]  player_soft_s, dealer_soft_s;
    logic [10:0] soft_unused_s;

    // Soft-ace counts and the dealer's post-add values drive no decisions
    assign soft_unused_s = {player_soft_s, dealer_soft_s, dealer_total_next_s};

    hand_accumulator u_player (
        .clk(i_clk), .reset(i_reset), .clear(clear_s), .add(add_player_s), .rank(i_cardRank),
        .total(player_total_s), .count(player_count_s), .soft_aces(player_soft_s),
        .total_next(player_total_next_s), .count_next(player_count_next_s)
    );

    hand_accumulator u_dealer (
        .clk(i_clk), .reset(i_reset), .clear(clear_s), .add(add_dealer_s), .rank(i_cardRank),
        .total(dealer_total_s), .count(dealer_count_s), .soft_aces(dealer_soft_s),
        .total_next(dealer_total_next_s), .count_next(dealer_count_next_s)
    );

    // Next-state, card routing and round result
    always_comb begin
        state_s      = state_r;
        result_s     = result_r;
        clear_s      = 1'b0;
        add_player_s = 1'b0;
        add_dealer_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    clear_s  = 1'b1;
                    result_s = RES_NONE;
                    state_s  = ST_DEAL_P1;
                end else begin
                    state_s  = state_r;
                end
            end
            ST_DEAL_P1, ST_DEAL_P2: begin
                if (i_cardValid) begin
                    add_player_s = 1'b1;
                    state_s      = (state_r == ST_DEAL_P1) ? ST_DEAL_D1 : ST_DEAL_D2;
                end else begin
                    state_s      = state_r;
                end
            end
            ST_DEAL_D1, ST_DEAL_D2: begin
                if (i_cardValid) begin
                    add_dealer_s = 1'b1;
                    state_s      = (state_r == ST_DEAL_D1) ? ST_DEAL_P2 : ST_PLAYER_TURN;
                end else begin
                    state_s      = state_r;
                end
            end
            ST_PLAYER_TURN: begin
                if (player_total_s == BUST_LIMIT || i_stand) begin
                    state_s = ST_DEALER_TURN;
                end else if (i_hit) begin
                    state_s = ST_PLAYER_DRAW;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PLAYER_DRAW: begin
                if (!i_cardValid) begin
                    state_s = state_r;
                end else if (player_total_next_s > BUST_LIMIT) begin
                    add_player_s = 1'b1;
                    state_s      = ST_RESOLVE;
                end else if (player_total_next_s == BUST_LIMIT || player_count_next_s == MAX_COUNT) begin
                    add_player_s = 1'b1;
                    state_s      = ST_DEALER_TURN;
                end else begin
                    add_player_s = 1'b1;
                    state_s      = ST_PLAYER_TURN;
                end
            end
            ST_DEALER_TURN: begin
                if (dealer_total_s >= STAND_TOTAL || dealer_count_s == MAX_COUNT) begin
                    state_s = ST_RESOLVE;
                end else begin
                    state_s = ST_DEALER_DRAW;
                end
            end
            ST_DEALER_DRAW: begin
                if (i_cardValid) begin
                    add_dealer_s = 1'b1;
                    state_s      = ST_DEALER_TURN;
                end else begin
                    state_s      = state_r;
                end
            end
            ST_RESOLVE: begin
                state_s = ST_DONE;
                if (player_total_s > BUST_LIMIT) begin
                    result_s = RES_DEALER_WIN;
                end else if (dealer_total_s > BUST_LIMIT) begin
                    result_s = RES_PLAYER_WIN;
                end else if (player_total_s > dealer_total_s) begin
                    result_s = RES_PLAYER_WIN;
                end else if (dealer_total_s > player_total_s) begin
                    result_s = RES_DEALER_WIN;
                end else begin
                    result_s = RES_PUSH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; decodes are taken from the next state
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            result_r  <= RES_NONE;
            turn_r    <= TURN_NONE;
            drawreq_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            result_r  <= result_s;
            turn_r    <= turn_of(state_s);
            drawreq_r <= is_draw_state(state_s);
        end
    end

    assign o_drawReq     = drawreq_r;
    assign o_playerTotal = player_total_s;
    assign o_dealerTotal = dealer_total_s;
    assign o_playerCount = player_count_s;
    assign o_dealerCount = dealer_count_s;
    assign o_turn        = turn_r;
    assign o_state       = state_r;
    assign o_result      = result_r;

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer: hands are modelled as queues of ranks
// and scored with blackjack rules; a negedge monitor compares every cycle.
module tb_deal_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic       i_hit = 1'b0;
    logic       i_stand = 1'b0;
    logic       i_cardValid = 1'b0;
    logic [3:0] i_cardRank = 4'd0;
    logic       o_drawReq;
    logic [4:0] o_playerTotal, o_dealerTotal;
    logic [2:0] o_playerCount, o_dealerCount;
    logic [1:0] o_turn;
    logic [3:0] o_state;
    logic [1:0] o_result;

    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;
    int  player_q[$];
    int  dealer_q[$];

    localparam int S_IDLE = 0, S_PTURN = 5, S_DTURN = 7, S_DDRAW = 8, S_DONE = 10;
    localparam int T_NONE = 0, T_PLAYER = 1, T_DEALER = 2;
    localparam int R_NONE = 0, R_PWIN = 1, R_DWIN = 2, R_PUSH = 3;

    deal_sequencer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_hit(i_hit), .i_stand(i_stand),
        .i_cardValid(i_cardValid), .i_cardRank(i_cardRank), .o_drawReq(o_drawReq),
        .o_playerTotal(o_playerTotal), .o_dealerTotal(o_dealerTotal),
        .o_playerCount(o_playerCount), .o_dealerCount(o_dealerCount),
        .o_turn(o_turn), .o_state(o_state), .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    function automatic int best_total(input int hand[$]);
        int s = 0;
        int aces = 0;
        foreach (hand[i]) begin
            if (hand[i] == 1) begin
                s += 11;
                aces++;
            end else if (hand[i] >= 10) begin
                s += 10;
            end else begin
                s += hand[i];
            end
        end
        while (s > 21 && aces > 0) begin
            s -= 10;
            aces--;
        end
        return s;
    endfunction

    function automatic int model_result();
        int p = best_total(player_q);
        int d = best_total(dealer_q);
        if (p > 21) return R_DWIN;
        if (d > 21) return R_PWIN;
        if (p > d) return R_PWIN;
        if (d > p) return R_DWIN;
        return R_PUSH;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Every-cycle comparison of the hand outputs against the queue model
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("mon_player_total", int'(o_playerTotal), best_total(player_q));
            check("mon_dealer_total", int'(o_dealerTotal), best_total(dealer_q));
            check("mon_player_count", int'(o_playerCount), player_q.size());
            check("mon_dealer_count", int'(o_dealerCount), dealer_q.size());
        end
    end

    task automatic pulse(input bit s, input bit h, input bit st, input bit clear_model);
        i_start = s;
        i_hit   = h;
        i_stand = st;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_hit   = 1'b0;
        i_stand = 1'b0;
        if (clear_model) begin
            player_q.delete();
            dealer_q.delete();
        end
    endtask

    task automatic give_card(input int rank, input bit to_player);
        int n = 0;
        while (o_drawReq !== 1'b1 && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        check("draw_req_wait", int'(o_drawReq === 1'b1), 1);
        if (o_drawReq === 1'b1) begin
            i_cardValid = 1'b1;
            i_cardRank  = 4'(rank);
            @(posedge i_clk);
            #1;
            i_cardValid = 1'b0;
            i_cardRank  = 4'd0;
            if (to_player) player_q.push_back(rank);
            else           dealer_q.push_back(rank);
        end
    endtask

    task automatic wait_state(input int target, input string name);
        int n = 0;
        while (int'(o_state) != target && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        check(name, int'(o_state), target);
    endtask

    task automatic check_done(input string tag, input int lit_result);
        wait_state(S_DONE, {tag, "_done"});
        check({tag, "_result_model"}, int'(o_result), model_result());
        check({tag, "_result_lit"}, int'(o_result), lit_result);
        check({tag, "_drawreq"}, int'(o_drawReq), 0);
        check({tag, "_turn"}, int'(o_turn), T_NONE);
    endtask

    initial begin
        int pin_q[$];
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int pin_q[$];
        pin_q = '{1, 1, 9};
        check("pin_model_aces", best_total(pin_q), 21);
        pin_q = '{10, 6, 9};
        check("pin_model_bust", best_total(pin_q), 25);

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        chk_en  = 1'b1;
        check("rst_state", int'(o_state), S_IDLE);
        check("rst_drawreq", int'(o_drawReq), 0);
        check("rst_turn", int'(o_turn), T_NONE);
        check("rst_result", int'(o_result), R_NONE);

        // Push: 17 vs 17, dealer stands on 17
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        give_card(10, 1'b1); give_card(9, 1'b0); give_card(7, 1'b1); give_card(8, 1'b0);
        wait_state(S_PTURN, "push_pturn");
        check("push_turn_player", int'(o_turn), T_PLAYER);
        check("push_ptotal_lit", int'(o_playerTotal), 17);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check_done("push", R_PUSH);
        check("push_dtotal_lit", int'(o_dealerTotal), 17);

        // Natural 21 skips player input; dealer draws to 20
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        give_card(1, 1'b1); give_card(5, 1'b0); give_card(13, 1'b1); give_card(6, 1'b0);
        give_card(9, 1'b0);
        check_done("nat21", R_PWIN);
        check("nat21_dtotal_lit", int'(o_dealerTotal), 20);

        // Player busts on a hit; dealer never draws
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        give_card(10, 1'b1); give_card(10, 1'b0); give_card(6, 1'b1); give_card(7, 1'b0);
        wait_state(S_PTURN, "bust_pturn");
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        give_card(9, 1'b1);
        check_done("bust", R_DWIN);
        check("bust_ptotal_lit", int'(o_playerTotal), 25);
        check("bust_dcount_lit", int'(o_dealerCount), 2);

        // Two aces then a nine: 11, 12, 21 and auto-advance to the dealer
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        give_card(1, 1'b1);
        @(negedge i_clk);
        check("aces_total_1", int'(o_playerTotal), 11);
        give_card(10, 1'b0); give_card(1, 1'b1);
        @(negedge i_clk);
        check("aces_total_2", int'(o_playerTotal), 12);
        give_card(6, 1'b0);
        wait_state(S_PTURN, "aces_pturn");
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        give_card(9, 1'b1);
        @(negedge i_clk);
        check("aces_total_3", int'(o_playerTotal), 21);
        check("aces_dealer_turn", int'(o_turn), T_DEALER);
        give_card(2, 1'b0);
        check_done("aces", R_PWIN);

        // Mid-round start ignored; hit+stand means stand; stall then reset
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        give_card(10, 1'b1); give_card(5, 1'b0); give_card(4, 1'b1); give_card(5, 1'b0);
        wait_state(S_PTURN, "stall_pturn");
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        check("midstart_ignored", int'(o_state), S_PTURN);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge i_clk);
        check("hitstand_dturn", int'(o_state), S_DTURN);
        @(negedge i_clk);
        check("stall_ddraw", int'(o_state), S_DDRAW);
        check("stall_turn", int'(o_turn), T_DEALER);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("stall_drawreq", int'(o_drawReq), 1);
        end
        i_reset     = 1'b1;
        i_cardValid = 1'b1;
        i_cardRank  = 4'd10;
        @(posedge i_clk);
        #1;
        player_q.delete();
        dealer_q.delete();
        i_reset     = 1'b0;
        i_cardValid = 1'b0;
        i_cardRank  = 4'd0;
        @(negedge i_clk);
        check("mid_rst_state", int'(o_state), S_IDLE);
        check("mid_rst_drawreq", int'(o_drawReq), 0);
        check("mid_rst_turn", int'(o_turn), T_NONE);
        check("mid_rst_result", int'(o_result), R_NONE);
        check("mid_rst_dcount", int'(o_dealerCount), 0);

        // A strobe without a request is ignored
        i_cardValid = 1'b1;
        i_cardRank  = 4'd7;
        @(posedge i_clk);
        #1;
        i_cardValid = 1'b0;
        i_cardRank  = 4'd0;
        @(negedge i_clk);
        check("idle_strobe_state", int'(o_state), S_IDLE);
        check("idle_strobe_pcount", int'(o_playerCount), 0);

        // Dealer stops at the card limit below the stand total
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        give_card(10, 1'b1); give_card(2, 1'b0); give_card(10, 1'b1); give_card(2, 1'b0);
        wait_state(S_PTURN, "max_pturn");
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        give_card(2, 1'b0); give_card(2, 1'b0); give_card(2, 1'b0);
        check_done("max", R_PWIN);
        check("max_dcount_lit", int'(o_dealerCount), 5);
        check("max_dtotal_lit", int'(o_dealerTotal), 10);

        @(negedge i_clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/deal_sequencer.md
DEAL_SEQUENCER -- requirements
Module: deal_sequencer

Interface
REQ-001 Parameter MAX_CARDS, default 5, is the maximum number of cards per hand.
REQ-002 Parameter DEALER_STAND, default 17, is the dealer total at or above which the dealer stands.
REQ-003 i_clk  in  1  single clock; all state changes occur on its rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_start  in  1  one-cycle pulse that begins a round.
REQ-006 i_hit  in  1  one-cycle pulse carrying the player HIT command.
REQ-007 i_stand  in  1  one-cycle pulse carrying the player STAND command.
REQ-008 i_cardValid  in  1  deck response strobe; i_cardRank is valid on this cycle.
REQ-009 i_cardRank  in  4  card rank: 1=ace, 2..10 pips, 11..13 face cards.
REQ-010 o_drawReq  out  1  card request to the deck.
REQ-011 o_playerTotal  out  5  best player total, unsigned.
REQ-012 o_dealerTotal  out  5  best dealer total, unsigned.
REQ-013 o_playerCount  out  3  number of cards held by the player.
REQ-014 o_dealerCount  out  3  number of cards held by the dealer.
REQ-015 o_turn  out  2  turnIndicator: NONE, PLAYER or DEALER.
REQ-016 o_state  out  4  gameState encoding of the current FSM state.
REQ-017 o_result  out  2  NONE, PLAYER_WIN, DEALER_WIN or PUSH.

Function
REQ-018 The FSM SHALL use these states: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER_TURN, PLAYER_DRAW, DEALER_TURN, DEALER_DRAW, RESOLVE, DONE.
REQ-019 i_start SHALL be honoured only in IDLE or DONE; it clears hands and o_result, then enters DEAL_P1 on the next edge.
REQ-020 In every DEAL_* and *_DRAW state, o_drawReq SHALL be high and SHALL remain high until the cycle i_cardValid=1 is seen; that edge accepts the card and advances the FSM.
REQ-021 i_cardValid SHALL be ignored while o_drawReq=0.
REQ-022 The card value SHALL be 11 for rank 1, 10 for ranks 10..13, and the rank otherwise.
REQ-023 An accepted card SHALL be added to its hand, and the total and count SHALL update on the same edge (1-cycle latency).
REQ-024 Each hand SHALL count its soft aces; while total>21 and softAces>0, 10 SHALL be subtracted and softAces decremented, once per accepted card.
REQ-025 Totals SHALL fit in 5 bits (max 31); no overflow path is permitted.
REQ-026 The initial deal order SHALL be P1 -> D1 -> P2 -> D2 -> PLAYER_TURN.
REQ-027 In PLAYER_TURN, i_hit SHALL go to PLAYER_DRAW and i_stand SHALL go to DEALER_TURN; if both are high, stand wins; commands arriving in any other state are ignored.
REQ-028 After a player card: total>21 -> RESOLVE; total==21 or count==MAX_CARDS -> DEALER_TURN; otherwise -> PLAYER_TURN.
REQ-029 A player total of 21 after the initial deal SHALL move PLAYER_TURN directly to DEALER_TURN.
REQ-030 DEALER_TURN: total>=DEALER_STAND (soft 17 included) or count==MAX_CARDS -> RESOLVE; otherwise -> DEALER_DRAW, returning to DEALER_TURN after the card is accepted.
REQ-031 RESOLVE SHALL set o_result in one cycle and enter DONE.
- Player bust -> DEALER_WIN.
- Otherwise dealer bust -> PLAYER_WIN.
- Otherwise the higher total wins; equal totals -> PUSH.
REQ-032 o_turn SHALL be PLAYER in PLAYER_TURN/PLAYER_DRAW, DEALER in DEALER_TURN/DEALER_DRAW, and NONE in all other states.
REQ-033 o_result and the hands SHALL hold in DONE until i_start or i_reset.

Reset
REQ-034 i_reset SHALL take effect at the next edge from any state, including mid-handshake.
- State -> IDLE; o_drawReq=0.
- All totals and counts = 0; o_turn=NONE; o_result=NONE.
REQ-035 A card strobed on the same cycle as i_reset SHALL be discarded.

Structure
REQ-036 The shared package SHALL hold:
- the gameState, turnIndicator and gameResult enums;
- the card rank type;
- BUST_LIMIT=21, ACE_HIGH=11 and FACE_VALUE=10.
REQ-037 One sub-module, hand_accumulator (clear, add, rank -> total, count, softAces), SHALL be instantiated twice: player and dealer.

Verification
REQ-038 Start, deal 10,9,7,8, stand -> player 17, dealer 17 stands, o_result=PUSH, o_drawReq low in DONE.
REQ-039 Deal 1,5,13,6, dealer draws 9 -> player 21 skips PLAYER_TURN input, dealer 20 stands, o_result=PLAYER_WIN.
REQ-040 Deal 10,10,6,7, hit with 9 -> player 25 bust, RESOLVE without any dealer draw, o_result=DEALER_WIN.
REQ-041 Player receives aces 1,1 then hits 9 -> total sequence 11, 12, 21, then auto-advance to DEALER_TURN.
REQ-042 Hold i_cardValid low for 5 cycles -> o_drawReq stays high with totals unchanged; i_reset asserted in that window -> IDLE with all outputs at 0.
REQ-043 i_hit and i_stand asserted together in PLAYER_TURN -> DEALER_TURN with no card drawn; i_start asserted mid-round -> ignored.
